// File: rtl/cycle_scheduler.sv
// Machine-cycle scheduler: divides clkin into DIV-clock machine cycles, emits phase enables,
// and assigns each cycle to ANTIC DMA, the CPU, or a WSYNC stall. Optional counters: CYCLE_SCHED_COUNT_EN.
module cycle_scheduler #(
  parameter int DIV      = 16,
  parameter int PHI1_LEN = 8
) (
  input  logic        clkin,
  input  logic        RST,
  input  logic        locked,
  input  logic        dma_req,
  input  logic        wsync_req,
  input  logic        hblank_start,
  output logic        phi0,
  output logic        phi1_en,
  output logic        phi2_en,
  output logic        cyc_start,
  output logic        dma_grant,
  output logic        cpu_rdy,
  output logic [15:0] cycle_count,
  output logic [15:0] stall_count,
  output logic        state_dbg
);

  localparam int PW = $clog2(DIV);

  typedef enum logic {WAIT_LOCK = 1'b0, RUN = 1'b1} state_t;

  state_t          state;
  logic [PW-1:0]   phase;
  logic [PW-1:0]   phase_next;
  logic            wsync_pend;
  logic            pend_next;
  logic            start;

  // The owner decision looks at the pend value as it will be after this edge, so a
  // wsync_req or hblank_start in the last clock of a cycle still counts at the boundary.
  always_comb begin
    pend_next  = wsync_req | (wsync_pend & ~hblank_start);
    phase_next = '0;
    if (state == RUN && phase != PW'(DIV - 1))
      phase_next = phase + PW'(1);
    start = (phase_next == '0);
  end

  always_ff @(posedge clkin) begin
    if (RST || !locked) begin
      state      <= WAIT_LOCK;
      phase      <= '0;
      wsync_pend <= 1'b0;
      phi0       <= 1'b0;
      phi1_en    <= 1'b0;
      phi2_en    <= 1'b0;
      cyc_start  <= 1'b0;
      dma_grant  <= 1'b0;
      cpu_rdy    <= 1'b0;
    end else begin
      state      <= RUN;
      phase      <= phase_next;
      wsync_pend <= pend_next;
      phi1_en    <= start;
      cyc_start  <= start;
      phi2_en    <= (phase_next == PW'(PHI1_LEN));
      phi0       <= (phase_next >= PW'(PHI1_LEN));
      // Ownership is latched only at the boundary and held for the whole cycle.
      if (start) begin
        dma_grant <= dma_req;
        cpu_rdy   <= ~dma_req & ~pend_next;
      end
    end
  end

  assign state_dbg = (state == RUN);

`ifdef CYCLE_SCHED_COUNT_EN
  always_ff @(posedge clkin) begin
    if (RST) begin
      cycle_count <= 16'h0000;
      stall_count <= 16'h0000;
    end else if (locked && start) begin
      cycle_count <= cycle_count + 16'd1;
      if (!dma_req && pend_next)
        stall_count <= stall_count + 16'd1;
    end
  end
`else
  assign cycle_count = 16'h0000;
  assign stall_count = 16'h0000;
`endif

endmodule

// File: doc/cycle_scheduler.md
# cycle_scheduler

Machine-cycle scheduler between the clock generator and the CPU/ANTIC datapath. Divides the master clock into fixed-length machine cycles, emits phase-1/phase-2 enables and a phi0 level, and assigns each cycle to either the CPU or an ANTIC DMA request. Also implements the WSYNC stall: the CPU is held off until the next horizontal-blank start. Sits directly after the DCM/clock-divider block and feeds the 6502 core's RDY and the bus multiplexer.

## Interface
Parameters:
- DIV, 16, master clocks per machine cycle; legal range DIV >= 4.
- PHI1_LEN, 8, master clocks spent in phase 1; legal range 1 <= PHI1_LEN <= DIV-1.

Ports:
- clkin  input  1  master clock; all logic on posedge.
- RST  input  1  synchronous, active-high reset.
- locked  input  1  clock-generator lock; scheduler idles while low.
- dma_req  input  1  ANTIC DMA request (level), sampled once per cycle.
- wsync_req  input  1  one-clkin pulse: CPU wrote WSYNC.
- hblank_start  input  1  one-clkin pulse at horizontal-blank start.
- phi0  output  1  registered phase level: 0 in phase 1, 1 in phase 2.
- phi1_en  output  1  one-clkin pulse at the first clock of each cycle.
- phi2_en  output  1  one-clkin pulse at the first clock of phase 2.
- cyc_start  output  1  asserted together with phi1_en.
- dma_grant  output  1  current cycle belongs to DMA.
- cpu_rdy  output  1  current cycle belongs to the CPU; low means the CPU is stalled.
- cycle_count  output  16  machine-cycle counter; present only under the macro.
- stall_count  output  16  count of CPU-stalled cycles; present only under the macro.

## Operation
- **States:**
  - WAIT_LOCK is entered on reset.
  - WAIT_LOCK -> RUN on the first clkin with locked=1.
  - RUN -> WAIT_LOCK on any clkin with locked=0. This takes effect immediately: phase is cleared, all outputs go to 0, and wsync_pend is cleared.
- **Phase counter:**
  - Width is $clog2(DIV).
  - In WAIT_LOCK it holds at 0.
  - In RUN it counts 0..DIV-1 and wraps to 0.
- **Owner decision:**
  - Made on the clkin edge at which phase becomes 0. This includes the RUN entry edge.
  - Inputs are dma_req and wsync_pend.
  - dma_req=1: dma_grant=1, cpu_rdy=0. DMA has priority over the CPU regardless of WSYNC.
  - Otherwise, wsync_pend=1: dma_grant=0, cpu_rdy=0 (stall cycle).
  - Otherwise: dma_grant=0, cpu_rdy=1.
  - dma_grant and cpu_rdy are held constant for the whole cycle.
- **wsync_pend:**
  - Set by wsync_req.
  - Cleared by hblank_start.
  - If both arrive on the same clkin, set wins.
  - A cleared pend releases the CPU at the next cycle boundary, never mid-cycle.
- **Counters (under the macro):**
  - cycle_count increments on every cycle start in RUN.
  - stall_count increments on each cycle start with cpu_rdy=0 and dma_grant=0.
  - Both wrap modulo 2^16, are cleared by RST, and hold in WAIT_LOCK.

## Timing
- **Reset values:** all outputs are 0, state is WAIT_LOCK, phase is 0, wsync_pend is 0.
- **All outputs are registered.**
- **Per cycle, relative to the phase-0 clock:**
  - phi1_en and cyc_start are high during the phase-0 clock only.
  - phi2_en is high during the phase-PHI1_LEN clock only.
  - phi0 is 1 for phases PHI1_LEN..DIV-1.
- **Lock latency:** the first phi1_en is high in the clock after the first clkin edge that samples locked=1.
- **Sampling window:** dma_req and wsync_pend are sampled only at the boundary edge; changes mid-cycle affect the next cycle only.
- **Stall latency:**
  - wsync_req at any phase stalls starting at the next boundary.
  - A wsync_req in the last clock before a boundary still stalls that next cycle.
- **Release latency:** hblank_start arriving k clocks before a boundary releases at that boundary, for k >= 1.

## Configuration
- **CYCLE_SCHED_COUNT_EN defined:** cycle_count and stall_count registers are implemented.
- **CYCLE_SCHED_COUNT_EN undefined:** both ports are tied to 16'h0000 and no counter logic is synthesized. All other behaviour is identical.

## Test plan
All scenarios use DIV=16 and PHI1_LEN=8.

- **Lock-up:** RST high 3 clocks, locked rises 5 clocks later -> outputs stay 0 until then; phi1_en next clock; phi2_en 8 clocks after; period 16 clocks; phi0 duty 8/16.
- **DMA steal:** dma_req=1 across cycles 2-3 -> dma_grant=1, cpu_rdy=0 exactly for those two cycles; dma_req dropped at phase 5 of cycle 3 does not shorten cycle 3.
- **WSYNC:**
  - wsync_req at phase 10 of cycle N -> cpu_rdy=0 from cycle N+1.
  - hblank_start at phase 3 of cycle N+4 -> cpu_rdy=1 at cycle N+5.
  - stall_count = 4 (macro on).
- **Simultaneous:**
  - wsync_req and hblank_start on the same clock -> stall persists until the next hblank_start.
  - dma_req during a stall -> dma_grant=1; stall_count does not increment.
- **Lock loss:** locked drops at phase 6 -> the next clock shows all outputs 0 and phase 0; relock restarts the cycle cleanly; a pending WSYNC is discarded.
- **Macro off:** same stimulus as the WSYNC scenario -> cycle_count = stall_count = 0; all other outputs match the macro-on run.
